// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM states, datapath width, reset PC and the
// opcode constants the fetch stage and control unit agree on.
package mips_pkg;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux: jump target beats branch target beats PC+4.
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] pc_plus4,
    input  logic [15:0]        imm16,
    input  logic [25:0]        jaddr,
    input  logic               pc_src,
    input  logic               jump,
    output logic [INSTR_W-1:0] next_pc
);
    logic [INSTR_W-1:0] br_off;

    always_comb begin
        br_off = {{14{imm16[15]}}, imm16, 2'b00};
        if (jump) begin
            next_pc = {pc_plus4[31:28], jaddr, 2'b00};
        end else if (pc_src) begin
            next_pc = pc_plus4 + br_off;
        end else begin
            next_pc = pc_plus4;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack read, instruction
// register with valid/ready handoff to decode.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        pc_src,
    input  logic        jump,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr
);
    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  next_pc;
    logic         capture, retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (imem_ack) state_d = HOLD;
            HOLD:    if (instr_ready) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Acks outside FETCH and retire inputs outside HOLD are dropped here.
    always_comb begin
        imem_req = (state_q == FETCH);
        capture  = (state_q == FETCH) && imem_ack;
        retire   = (state_q == HOLD) && instr_ready;
    end

    next_pc_sel u_next_pc_sel (
        .pc_plus4 (pc_plus4),
        .imm16    (imm16),
        .jaddr    (jaddr),
        .pc_src   (pc_src),
        .jump     (jump),
        .next_pc  (next_pc)
    );

    always_comb begin
        pc_d          = retire ? next_pc : pc_q;
        instr_d       = capture ? imem_rdata : instr_q;
        instr_valid_d = capture | (instr_valid_q & ~retire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4;
    logic        instr_valid, instr_ready, pc_src, jump;
    logic [15:0] imm16;
    logic [25:0] jaddr;

    // secondary instances for reset-PC dependent cases
    logic        req_w, valid_w, req_j, valid_j;
    logic [31:0] addr_w, instr_w, pc_w, p4_w, addr_j, instr_j, pc_j, p4_j;

    int checks = 0;
    int errors = 0;

    // memory responder controls
    int  lat_lo = 0, lat_hi = 0;
    bit  spur_en = 0, force_ack = 0, fixed_en = 0;

    // logs filled by the model process
    logic [31:0] a_log[$];
    logic [31:0] w_log[$];
    logic [31:0] j_log[$];
    int          cap_cnt = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
        .pc_plus4(pc_plus4), .pc_src(pc_src), .jump(jump), .imm16(imm16),
        .jaddr(jaddr)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(req_w), .imem_rdata(32'h0000_0020), .instr(instr_w),
        .instr_valid(valid_w), .instr_ready(1'b1), .pc(pc_w),
        .pc_plus4(p4_w), .pc_src(1'b0), .jump(1'b0), .imm16(16'h0000),
        .jaddr(26'h0)
    );

    fetch_unit #(.RESET_PC(32'h3000_0010)) dut_j (
        .clk(clk), .rst_n(rst_n), .imem_req(req_j), .imem_addr(addr_j),
        .imem_ack(req_j), .imem_rdata(32'h0800_0040), .instr(instr_j),
        .instr_valid(valid_j), .instr_ready(1'b1), .pc(pc_j),
        .pc_plus4(p4_j), .pc_src(1'b1), .jump(1'b1), .imm16(16'h0004),
        .jaddr(26'h000_0040)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] target(input logic [31:0] cur_pc, input logic j,
                                           input logic s, input logic [15:0] im,
                                           input logic [25:0] ja);
        logic [31:0] p4;
        p4 = cur_pc + 32'd4;
        if (j) return {p4[31:28], ja, 2'b00};
        if (s) return p4 + 32'($signed(im)) * 32'd4;
        return p4;
    endfunction

    // Reference model: what each cycle must look like, advanced at negedge
    // from the inputs that the next rising edge will sample.
    initial begin
        logic        m_known, m_idle, m_req, m_valid;
        logic [31:0] m_pc, m_instr;
        logic        p_req, p_valid, p_w, p_j;
        m_known = 0; m_idle = 0; m_req = 0; m_valid = 0; m_pc = 0; m_instr = 0;
        p_req = 0; p_valid = 0; p_w = 0; p_j = 0;
        forever begin
            @(negedge clk);
            if (m_known) begin
                chk("imem_req", imem_req, m_req);
                chk("instr_valid", instr_valid, m_valid);
                chk("pc", pc, m_pc);
                chk("imem_addr", imem_addr, m_pc);
                chk("pc_plus4", pc_plus4, m_pc + 32'd4);
                chk("instr", instr, m_instr);
            end
            if (imem_req === 1'b1 && !p_req) a_log.push_back(imem_addr);
            if (instr_valid === 1'b1 && !p_valid) cap_cnt++;
            if (req_w === 1'b1 && !p_w) w_log.push_back(addr_w);
            if (req_j === 1'b1 && !p_j) j_log.push_back(addr_j);
            p_req = (imem_req === 1'b1); p_valid = (instr_valid === 1'b1);
            p_w = (req_w === 1'b1); p_j = (req_j === 1'b1);

            if (!rst_n) begin
                m_known = 1; m_idle = 1; m_req = 0; m_valid = 0;
                m_pc = 32'h0; m_instr = 32'h0;
            end else if (m_idle) begin
                m_idle = 0; m_req = 1;
            end else if (m_req && imem_ack) begin
                m_req = 0; m_valid = 1; m_instr = imem_rdata;
            end else if (m_valid && instr_ready) begin
                m_valid = 0; m_req = 1;
                m_pc = target(m_pc, jump, pc_src, imm16, jaddr);
            end
        end
    end

    // Instruction memory with programmable latency and optional spurious acks.
    initial begin
        int cnt, lat;
        cnt = 0; lat = 0;
        imem_ack = 1'b0; imem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            imem_ack   = 1'b0;
            imem_rdata = fixed_en ? 32'h8C08_0004 : $urandom;
            if (imem_req === 1'b1) begin
                if (cnt == 0) lat = $urandom_range(lat_hi, lat_lo);
                if (cnt >= lat) begin
                    imem_ack = 1'b1; cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                if (spur_en && $urandom_range(3, 0) == 0) imem_ack = 1'b1;
            end
            if (force_ack) imem_ack = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string name);
        bit found = 0;
        for (int i = 0; i < 40; i++) begin
            if (instr_valid === 1'b1) begin found = 1; break; end
            tick();
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic scramble();
        pc_src = 1'($urandom); jump = 1'($urandom);
        imm16 = 16'($urandom); jaddr = 26'($urandom);
    endtask

    task automatic retire(input logic j, input logic s, input logic [15:0] im,
                          input logic [25:0] ja);
        jump = j; pc_src = s; imm16 = im; jaddr = ja; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        scramble();
        wait_valid("retire_wait");
    endtask

    initial begin
        logic [31:0] a0, i0, p0;
        bit found;
        rst_n = 1'b0; instr_ready = 1'b0; pc_src = 0; jump = 0; imm16 = 0; jaddr = 0;

        // basic streaming: ack one cycle after req, ready held high
        lat_lo = 1; lat_hi = 1; fixed_en = 1; instr_ready = 1'b1;
        repeat (3) tick();
        a_log.delete(); w_log.delete(); j_log.delete();
        rst_n = 1'b1;
        repeat (12) tick();
        if (a_log.size() >= 3) begin
            chk("seq_addr0", a_log[0], 32'h0);
            chk("seq_addr1", a_log[1], 32'h4);
            chk("seq_addr2", a_log[2], 32'h8);
        end else chk("seq_count", 32'(a_log.size()), 32'd3);
        if (w_log.size() >= 2) begin
            chk("wrap_first", w_log[0], 32'hFFFF_FFFC);
            chk("wrap_next", w_log[1], 32'h0000_0000);
        end else chk("wrap_count", 32'(w_log.size()), 32'd2);
        if (j_log.size() >= 2) begin
            chk("jump_first", j_log[0], 32'h3000_0010);
            chk("jump_wins", j_log[1], 32'h3000_0100);
        end else chk("jump_count", 32'(j_log.size()), 32'd2);

        // slow memory: 5-cycle ack delay
        instr_ready = 1'b0;
        wait_valid("lw_wait");
        chk("lw_instr", instr, 32'h8C08_0004);
        fixed_en = 0; lat_lo = 5; lat_hi = 5;
        instr_ready = 1'b1;
        tick();
        cap_cnt = 0;
        a0 = imem_addr;
        for (int i = 0; i < 5; i++) begin
            chk("slow_req", imem_req, 1'b1);
            chk("slow_addr", imem_addr, a0);
            tick();
        end
        instr_ready = 1'b0;
        repeat (3) tick();
        chk("slow_valid", instr_valid, 1'b1);
        chk("slow_captures", 32'(cap_cnt), 32'd1);

        // downstream stall in HOLD, branch inputs toggling meanwhile
        i0 = instr; p0 = pc;
        for (int i = 0; i < 4; i++) begin
            scramble();
            tick();
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_instr", instr, i0);
            chk("stall_pc", pc, p0);
            chk("stall_req", imem_req, 1'b0);
        end

        // branch / jump targets and wrap via branch
        lat_lo = 0; lat_hi = 2;
        retire(1'b1, 1'b0, 16'h1234, 26'h000_0040);
        chk("jump_to_100", pc, 32'h0000_0100);
        retire(1'b0, 1'b1, 16'hFFFF, 26'h3FF_FFFF);
        chk("branch_self", pc, 32'h0000_0100);
        retire(1'b0, 1'b1, 16'h0003, 26'h155_5555);
        chk("branch_fwd", pc, 32'h0000_0110);
        retire(1'b0, 1'b1, 16'hFFBA, 26'h0);
        chk("branch_back", pc, 32'hFFFF_FFFC);
        retire(1'b0, 1'b0, 16'hFFFF, 26'h3FF_FFFF);
        chk("pc_wrap", pc, 32'h0000_0000);

        // reset during an outstanding fetch, then a late ack in IDLE
        lat_lo = 4; lat_hi = 4; instr_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin found = 1; break; end
            tick();
        end
        chk("abort_wait_req", 32'(found), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_req", imem_req, 1'b0);
        chk("abort_pc", pc, 32'h0);
        chk("abort_valid", instr_valid, 1'b0);
        rst_n = 1'b1; force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        chk("late_ack_valid", instr_valid, 1'b0);
        chk("late_ack_req", imem_req, 1'b1);
        chk("late_ack_instr", instr, 32'h0);

        // randomized traffic with spurious acks and occasional resets
        lat_lo = 0; lat_hi = 3; spur_en = 1;
        for (int i = 0; i < 600; i++) begin
            instr_ready = ($urandom_range(9, 0) < 7);
            scramble();
            rst_n = ($urandom_range(199, 0) != 0);
            tick();
        end
        rst_n = 1'b1; instr_ready = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
